// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_e   : responder FSM encoding (IDLE, WAIT, RESP)
//   DSIZE_DEF : default data word width
//   WAIT_MAX  : largest supported WAIT_STATES value
//   CNT_W     : wait-state counter width
package dmem_pkg;
    localparam int DSIZE_DEF = 16;
    localparam int WAIT_MAX  = 15;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage request/response bundle.
//   master : initiator (EXE/MEM register) drives req_*, observes ready/rsp/busy
//   slave  : responder drives req_ready, rsp_*, busy
// rsp_err exists only when DMEM_RANGE_CHECK_EN is defined.
interface dmem_if #(parameter int DSIZE = 16);
    logic             req_valid;
    logic             req_ready;
    logic             req_wen;
    logic [DSIZE-1:0] req_addr;
    logic [DSIZE-1:0] req_wdata;
    logic             rsp_valid;
    logic [DSIZE-1:0] rsp_rdata;
    logic             busy;
`ifdef DMEM_RANGE_CHECK_EN
    logic             rsp_err;
`endif

    modport master (
`ifdef DMEM_RANGE_CHECK_EN
        input  rsp_err,
`endif
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
`ifdef DMEM_RANGE_CHECK_EN
        output rsp_err,
`endif
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DSIZE word storage.
//   clk, rst          : clock, async active-low clear of all words and rdata
//   we/waddr/wdata    : single synchronous write port
//   rd_en/raddr       : registered read; rdata holds when rd_en is low
//   rd_byp/byp_data   : load byp_data into the read register instead of a word
module dmem_array #(
    parameter int DSIZE = 16,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr,
    input  logic             rd_byp,
    input  logic [DSIZE-1:0] byp_data,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rdata <= '0;
        else if (rd_en) rdata <= rd_byp ? byp_data : mem[raddr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with programmable wait states.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (clears FSM and storage)
//   bus  : dmem_if.slave request/response channel
// Parameters: DSIZE word width, AW index width, WAIT_STATES (0..15).
// Optional: define DMEM_RANGE_CHECK_EN to add bus.rsp_err and block
// out-of-range accesses (nonzero address bits above AW).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DSIZE       = DSIZE_DEF,
    parameter int AW          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic    clk,
    input  logic    rst,
    dmem_if.slave   bus
);
    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_cfg_err
        $fatal(1, "dmem_responder: WAIT_STATES=%0d outside 0..%0d", WAIT_STATES, WAIT_MAX);
    end

    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             wen_q;
    logic [AW-1:0]    addr_q;
    logic [DSIZE-1:0] wdata_q;
    logic             accept;

    // Request fields as seen on the edge entering RESP: straight from the bus
    // when coming from IDLE (zero wait states), otherwise the latched copy.
    logic             from_req;
    logic             cur_wen;
    logic [AW-1:0]    cur_addr;
    logic [DSIZE-1:0] cur_wdata;
    logic             rd_byp;
    logic [DSIZE-1:0] byp_data;
    logic             we;

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: if (cnt == CNT_W'(1)) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (accept)         cnt <= WS_CNT;
        else if (state == WAIT)  cnt <= cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wen_q   <= bus.req_wen;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    assign from_req  = (state == IDLE);
    assign cur_wen   = from_req ? bus.req_wen            : wen_q;
    assign cur_addr  = from_req ? bus.req_addr[AW-1:0]   : addr_q;
    assign cur_wdata = from_req ? bus.req_wdata          : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    logic cur_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= |bus.req_addr[DSIZE-1:AW];
    end

    assign cur_err     = from_req ? |bus.req_addr[DSIZE-1:AW] : err_q;
    // Out-of-range loads return zero; stores still echo their data.
    assign rd_byp      = cur_wen || cur_err;
    assign byp_data    = cur_wen ? cur_wdata : '0;
    assign we          = (state == RESP) && wen_q && !err_q;
    assign bus.rsp_err = (state == RESP) && err_q;
`else
    // Upper address bits alias away in this build.
    logic unused_hi;
    assign unused_hi = ^bus.req_addr[DSIZE-1:AW];
    assign rd_byp    = cur_wen;
    assign byp_data  = cur_wdata;
    assign we        = (state == RESP) && wen_q;
`endif

    // The read register is loaded on the edge entering RESP, so rsp_rdata is
    // valid for the whole RESP cycle and holds afterwards. Stores commit on
    // the edge leaving RESP.
    dmem_array #(.DSIZE(DSIZE), .AW(AW)) u_array (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (addr_q),
        .wdata    (wdata_q),
        .rd_en    (state_nx == RESP),
        .raddr    (cur_addr),
        .rd_byp   (rd_byp),
        .byp_data (byp_data),
        .rdata    (bus.rsp_rdata)
    );

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. Two instances
// (WAIT_STATES = 2 and 0) share one stimulus set; sel picks the active one.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v, wen, sel;
    logic [15:0] addr, wdata;

    dmem_if #(.DSIZE(16)) bus2 ();
    dmem_if #(.DSIZE(16)) bus0 ();

    assign bus2.req_valid = v & ~sel;
    assign bus2.req_wen   = wen;
    assign bus2.req_addr  = addr;
    assign bus2.req_wdata = wdata;
    assign bus0.req_valid = v & sel;
    assign bus0.req_wen   = wen;
    assign bus0.req_addr  = addr;
    assign bus0.req_wdata = wdata;

    dmem_responder #(.DSIZE(16), .AW(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));
    dmem_responder #(.DSIZE(16), .AW(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));

    logic        rdy, rsp_v, bsy;
    logic [15:0] rsp_d;
    assign rdy   = sel ? bus0.req_ready : bus2.req_ready;
    assign rsp_v = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign bsy   = sel ? bus0.busy      : bus2.busy;
    assign rsp_d = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
`ifdef DMEM_RANGE_CHECK_EN
    logic rerr;
    assign rerr = sel ? bus0.rsp_err : bus2.rsp_err;
`endif

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [2][256];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the oldest expectation on each rsp_valid pulse.
    always @(negedge clk) begin
        if (rst && rsp_v) begin
            exp_t e;
            n_rsp++;
            if (q.size() == 0) begin
                chk("rsp_unexp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rdata", rsp_d, e.data);
                chk("latency", cyc + 1 - e.acc, sel ? 1 : 3);
`ifdef DMEM_RANGE_CHECK_EN
                chk("rsp_err", rerr, e.err);
`endif
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) model[d][i] = 16'h0000;
    endtask

    // Called at the negedge before the accepting edge.
    task automatic push(logic w, logic [15:0] a, logic [15:0] d);
        exp_t        e;
        logic [7:0]  idx;
        logic        oor;
        idx = a[7:0];
        oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        oor = |a[15:8];
`endif
        e.err = oor;
        e.acc = cyc + 1;
        if (w) begin
            e.data = d;
            if (!oor) model[sel][idx] = d;
        end else begin
            e.data = oor ? 16'h0000 : model[sel][idx];
        end
        q.push_back(e);
    endtask

    task automatic issue(logic w, logic [15:0] a, logic [15:0] d);
        int n;
        @(negedge clk);
        v = 1'b1; wen = w; addr = a; wdata = d;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
            v = 1'b0;
        end else begin
            push(w, a, d);
            @(posedge clk);
            #1;
            v = 1'b0;
            chk("busy_after_acc", bsy, 1);
            chk("rdy_after_acc", rdy, 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // valid held high with fields changing every cycle; only accept-cycle
    // values may be used, and accepts must be ws+2 cycles apart.
    task automatic burst(int n, int ws);
        int last, nacc, rsp0;
        last = -1; nacc = 0; rsp0 = n_rsp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v     = 1'b1;
            wen   = (k % 2 == 0);
            addr  = 16'h0040 + 16'(k % 3);
            wdata = 16'hA000 + 16'(k);
            if (rdy) begin
                if (last >= 0) chk("spacing", cyc + 1 - last, ws + 2);
                last = cyc + 1;
                push(wen, addr, wdata);
                nacc++;
            end
        end
        @(posedge clk);
        #1;
        v = 1'b0;
        drain();
        chk("burst_rsp_count", n_rsp - rsp0, nacc);
    endtask

    initial begin
        v = 1'b0; wen = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        clear_model();

        // reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy2",  bus2.req_ready, 1);
        chk("rst_busy2", bus2.busy,      0);
        chk("rst_vld2",  bus2.rsp_valid, 0);
        chk("rst_data2", bus2.rsp_rdata, 0);
        chk("rst_rdy0",  bus0.req_ready, 1);
        chk("rst_busy0", bus0.busy,      0);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 16'h0005, 16'h0000);
        drain();

        // WAIT_STATES = 2: store/load, top index, alias
        issue(1'b1, 16'h0012, 16'hBEEF);
        drain();
        issue(1'b0, 16'h0012, 16'h0000);
        drain();
        issue(1'b1, 16'h00FF, 16'h7E57);
        issue(1'b0, 16'h00FF, 16'h0000);
        issue(1'b1, 16'h0103, 16'h00AA);
        issue(1'b0, 16'h0003, 16'h0000);
        drain();
        burst(14, 2);

        // WAIT_STATES = 0
        @(posedge clk);
        #1 sel = 1'b1;
        issue(1'b1, 16'h0001, 16'h1234);
        issue(1'b0, 16'h0001, 16'h0000);
        drain();
        burst(8, 0);

        // reset during WAIT of a store
        @(posedge clk);
        #1 sel = 1'b0;
        issue(1'b1, 16'h0007, 16'h5555);
        @(negedge clk);
        chk("busy_wait", bsy, 1);
        rst = 1'b0;
        q.delete();
        clear_model();
        #1;
        chk("mid_rst_rdy",  rdy,   1);
        chk("mid_rst_busy", bsy,   0);
        chk("mid_rst_vld",  rsp_v, 0);
        chk("mid_rst_data", rsp_d, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 16'h0007, 16'h0000);
        issue(1'b0, 16'h0012, 16'h0000);
        drain();

        repeat (3) @(negedge clk);
        chk("q_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end
endmodule
